mdu_unit: RTL
=============

// Module: mdu_unit
// PURPOSE
//   Multiply/divide unit in the E stage of the 5-stage MIPS pipeline. Executes mult/multu/div/divu
//   with a fixed multi-cycle latency and owns the HI/LO registers. Serves mthi/mtlo/mfhi/mflo.
//   Drives busy to the hazard/stall logic, which holds md/mt/mf instructions in D while (busy | E_md).
// PARAMETERS
//   MULT_CYCLES  5   busy duration for mult/multu, in cycles; legal range 1..15
//   DIV_CYCLES   10  busy duration for div/divu, in cycles; legal range 1..15
// PORTS
//   clk        in   1   single clock; all state updates on the rising edge
//   reset      in   1   asynchronous, active-low; clears all state immediately
//   start      in   1   E-stage instruction is mult/multu/div/divu; one-cycle qualifier
//   mdu_op     in   3   0 NOP, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO, 7 MF (fixed encoding)
//   mf_hi      in   1   for MF only: 1 selects HI, 0 selects LO
//   req        in   1   exception/interrupt flush of the E-stage instruction this cycle
//   A          in   32  forwarded rs operand
//   B          in   32  forwarded rt operand
//   busy       out  1   operation in flight
//   hi         out  32  HI register, architectural value
//   lo         out  32  LO register, architectural value
//   mdu_out    out  32  mf_hi ? hi : lo; combinational; consumed by the E-stage result mux
// BEHAVIOUR
//   Reset: busy=0, hi=0, lo=0, counter=0, shadow result=0. Reset takes effect asynchronously,
//     including while an operation is in flight; the pending result is discarded.
//   Issue: the op is accepted on a rising edge when start=1, req=0, busy=0, and mdu_op is 1..4.
//     On that edge:
//       - shadow{hi,lo} <= result;
//       - cnt <= N, where N = MULT_CYCLES for mult/multu and DIV_CYCLES for div/divu;
//       - busy <= 1.
//   Results:
//     MULT: signed 64-bit A*B; hi=[63:32], lo=[31:0].
//     MULTU: unsigned 64-bit A*B, same split.
//     DIV: lo = signed quotient truncated toward zero; hi = remainder with the sign of the dividend.
//       0x80000000 / -1 gives lo=0x80000000, hi=0.
//     DIVU: unsigned quotient and remainder.
//     Divide by zero (B==0): the op is accepted and busy runs its full DIV_CYCLES, but the
//       commit leaves hi and lo unchanged.
//   Countdown: while busy, cnt decrements on every edge. On the edge where cnt==1:
//     {hi,lo} <= shadow and busy <= 0.
//     Net effect: busy is high for exactly N cycles, and the new hi/lo are visible in the cycle
//     after busy falls.
//   MTHI/MTLO: when req=0 and busy=0, hi<=A (op 5) or lo<=A (op 6) on the edge.
//     No busy cycle. These ops ignore start.
//   MF: purely combinational, reads current hi/lo; no state change.
//   Flush: req=1 suppresses any issue, MTHI or MTLO in the same cycle. req does NOT abort an
//     operation already in flight; it completes and commits.
//   Ops presented while busy=1: ignored (no state change). The stall logic prevents this;
//     the bench flags it as an error.
//   Issue while mdu_op is 0 or 5..7 and start=1: ignored; the bench flags it as an error.
//   Width rules: the multiply product is a full 64 bits; operands are sign-extended (signed
//     ops) or zero-extended (unsigned ops) to 64 bits before multiplying. cnt is 4 bits wide.
// STRUCTURE
//   Shared package mdu_pkg: mdu_op encodings (MDU_NOP .. MDU_MF) and the default cycle counts.
//   The E-stage controller reuses the same op encodings.
//   One sub-module: mdu_arith, combinational; computes the 64-bit {hi,lo} result and a
//     div-by-zero flag from (mdu_op, A, B). The top level holds cnt, busy, shadow, hi and lo.
// TESTING
//   1. MULT A=0xFFFFFFFE (-2), B=3 -> busy high for exactly 5 cycles; then hi=0xFFFFFFFF,
//      lo=0xFFFFFFFA.
//   2. MULTU A=0xFFFFFFFF, B=2 -> hi=0x00000001, lo=0xFFFFFFFE.
//   3. DIV A=-7, B=2 -> busy for 10 cycles; then lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1).
//      DIVU with the same operands -> lo=0x7FFFFFFC, hi=0x00000001.
//   4. Preload hi=0x11, lo=0x22 via MTHI/MTLO. Then DIV with B=0 -> busy runs 10 cycles;
//      hi/lo still read 0x11/0x22. MF with mf_hi=1 -> mdu_out=0x11.
//   5. Issue MULT with req=1 -> busy stays 0, hi/lo unchanged.
//      Issue MULT, then assert req in cycle 2 -> the op still commits after 5 cycles.
//   6. Issue DIV, pull reset low in cycle 4 -> busy, hi and lo read 0 immediately; after
//      release, no commit occurs.

Source files
------------

// File: rtl/mdu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mdu_pkg
//  Description : Shared operation encodings and default latencies for the
//                multiply/divide unit and the E-stage controller.
//  Revision    : 1.0 - initial release
// ============================================================================
package mdu_pkg;

    typedef enum logic [2:0] {
        MDU_NOP   = 3'd0,
        MDU_MULT  = 3'd1,
        MDU_MULTU = 3'd2,
        MDU_DIV   = 3'd3,
        MDU_DIVU  = 3'd4,
        MDU_MTHI  = 3'd5,
        MDU_MTLO  = 3'd6,
        MDU_MF    = 3'd7
    } mdu_op_e;

    localparam int MULT_CYCLES_DEF = 5;
    localparam int DIV_CYCLES_DEF  = 10;

    // True for the ops that occupy the unit for several cycles.
    function automatic logic is_md_op(input logic [2:0] op);
        return (op >= 3'(MDU_MULT)) && (op <= 3'(MDU_DIVU));
    endfunction

    // True for the divide ops (selects the longer latency).
    function automatic logic is_div_op(input logic [2:0] op);
        return (op == 3'(MDU_DIV)) || (op == 3'(MDU_DIVU));
    endfunction

endpackage
`default_nettype wire

// File: rtl/mdu_if.sv
`default_nettype none
// ============================================================================
//  Module      : mdu_if
//  Description : E-stage to multiply/divide unit signal bundle.
//  Revision    : 1.0 - initial release
// ============================================================================
interface mdu_if;
    logic        start;
    logic [2:0]  mdu_op;
    logic        mf_hi;
    logic        req;
    logic [31:0] A;
    logic [31:0] B;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;
    logic [31:0] mdu_out;

    modport master (
        output start, mdu_op, mf_hi, req, A, B,
        input  busy, hi, lo, mdu_out
    );

    modport slave (
        input  start, mdu_op, mf_hi, req, A, B,
        output busy, hi, lo, mdu_out
    );
endinterface
`default_nettype wire

// File: rtl/mdu_arith.sv
`default_nettype none
// ============================================================================
//  Module      : mdu_arith
//  Description : Combinational 64-bit {hi,lo} result for mult/multu/div/divu
//                plus a divide-by-zero flag.
//  Revision    : 1.0 - initial release
// ============================================================================
module mdu_arith
    import mdu_pkg::*;
(
    input  wire logic [2:0]  i_op,
    input  wire logic [31:0] i_a,
    input  wire logic [31:0] i_b,
    output logic      [63:0] o_result,
    output logic             o_div_zero
);

    logic [63:0] w_a_sx;
    logic [63:0] w_b_sx;
    logic [63:0] w_prod_s;
    logic [63:0] w_prod_u;
    logic        w_b_zero;
    logic [31:0] w_b_safe;
    logic        w_div_ovf;
    logic [31:0] w_quot_s;
    logic [31:0] w_rem_s;
    logic [31:0] w_quot_u;
    logic [31:0] w_rem_u;

    assign w_a_sx   = {{32{i_a[31]}}, i_a};
    assign w_b_sx   = {{32{i_b[31]}}, i_b};
    assign w_prod_s = 64'($signed(w_a_sx) * $signed(w_b_sx));
    assign w_prod_u = {32'd0, i_a} * {32'd0, i_b};

    // Divisor forced to 1 on zero so the dividers never see an undefined case;
    // the result is discarded via o_div_zero anyway.
    assign w_b_zero  = (i_b == 32'd0);
    assign w_b_safe  = w_b_zero ? 32'd1 : i_b;
    assign w_div_ovf = (i_a == 32'h8000_0000) && (i_b == 32'hFFFF_FFFF);
    assign w_quot_s  = 32'($signed(i_a) / $signed(w_b_safe));
    assign w_rem_s   = 32'($signed(i_a) % $signed(w_b_safe));
    assign w_quot_u  = i_a / w_b_safe;
    assign w_rem_u   = i_a % w_b_safe;

    // Select the result for the presented op.
    always_comb begin
        o_result   = 64'd0;
        o_div_zero = 1'b0;
        case (i_op)
            3'(MDU_MULT):  o_result = w_prod_s;
            3'(MDU_MULTU): o_result = w_prod_u;
            3'(MDU_DIV): begin
                o_div_zero = w_b_zero;
                if (w_div_ovf) o_result = {32'd0, 32'h8000_0000};
                else           o_result = {w_rem_s, w_quot_s};
            end
            3'(MDU_DIVU): begin
                o_div_zero = w_b_zero;
                o_result   = {w_rem_u, w_quot_u};
            end
            default: o_result = 64'd0;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/mdu_unit.sv
`default_nettype none
// ============================================================================
//  Module      : mdu_unit
//  Description : Fixed-latency multiply/divide unit owning HI/LO. Result is
//                computed at issue into a shadow register and committed when
//                the busy countdown expires.
//  Revision    : 1.0 - initial release
// ============================================================================
module mdu_unit
    import mdu_pkg::*;
#(
    parameter int MULT_CYCLES = MULT_CYCLES_DEF,
    parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
    input  wire logic clk,
    input  wire logic reset,
    mdu_if.slave      bus
);

    localparam logic [3:0] c_mult_cnt = 4'(MULT_CYCLES);
    localparam logic [3:0] c_div_cnt  = 4'(DIV_CYCLES);

    logic [3:0]  r_cnt;
    logic        r_busy;
    logic [63:0] r_shadow;
    logic        r_div_zero;
    logic [31:0] r_hi;
    logic [31:0] r_lo;

    logic [63:0] w_result;
    logic        w_div_zero;
    logic        w_issue;
    logic        w_idle_ok;

    mdu_arith u_arith (
        .i_op       (bus.mdu_op),
        .i_a        (bus.A),
        .i_b        (bus.B),
        .o_result   (w_result),
        .o_div_zero (w_div_zero)
    );

    // Nothing new is accepted while flushed or while an op is in flight.
    assign w_idle_ok = !bus.req && !r_busy;
    assign w_issue   = w_idle_ok && bus.start && is_md_op(bus.mdu_op);

    // Issue, countdown/commit and MTHI/MTLO writes.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt      <= 4'd0;
            r_busy     <= 1'b0;
            r_shadow   <= 64'd0;
            r_div_zero <= 1'b0;
            r_hi       <= 32'd0;
            r_lo       <= 32'd0;
        end else if (r_busy) begin
            r_cnt <= r_cnt - 4'd1;
            if (r_cnt == 4'd1) begin
                r_busy <= 1'b0;
                if (!r_div_zero) begin
                    r_hi <= r_shadow[63:32];
                    r_lo <= r_shadow[31:0];
                end
            end
        end else if (w_issue) begin
            r_shadow   <= w_result;
            r_div_zero <= w_div_zero;
            r_cnt      <= is_div_op(bus.mdu_op) ? c_div_cnt : c_mult_cnt;
            r_busy     <= 1'b1;
        end else if (w_idle_ok) begin
            if (bus.mdu_op == 3'(MDU_MTHI)) r_hi <= bus.A;
            if (bus.mdu_op == 3'(MDU_MTLO)) r_lo <= bus.A;
        end
    end

    assign bus.busy    = r_busy;
    assign bus.hi      = r_hi;
    assign bus.lo      = r_lo;
    assign bus.mdu_out = bus.mf_hi ? r_hi : r_lo;

endmodule
`default_nettype wire
